unsaved_switch_in: RTL and testbench

UNSAVED_SWITCH_IN -- requirements
Module: unsaved_switch_in

---
 rtl/unsaved_switch_in.sv | 127 ++++++++++++
 tb/tb_unsaved_switch_in.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsaved_switch_in.sv
// Debounced switch/key input port with rising-edge capture and masked interrupt,
// exposed as a four-word Avalon-MM slave.
module unsaved_switch_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_DIR   = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0]            sync1_r;
    logic [WIDTH-1:0]            sync2_r;
    logic [WIDTH-1:0]            deb_r;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0]            irqmask_r;
    logic [WIDTH-1:0]            edgecapture_r;
    logic                        irq_r;

    logic [WIDTH-1:0]            deb_next_s;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_next_s;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_inc_s;
    logic [WIDTH-1:0]            irqmask_next_s;
    logic [WIDTH-1:0]            edgecapture_next_s;
    logic [WIDTH-1:0]            clear_mask_s;
    logic                        wr_s;
    logic [31:0]                 readdata_s;

    // Bits that go low-to-high between the current and next debounced level.
    function automatic logic [WIDTH-1:0] rise_mask(
        input logic [WIDTH-1:0] prev_level,
        input logic [WIDTH-1:0] next_level
    );
        rise_mask = next_level & ~prev_level;
    endfunction

    assign wr_s = chipselect & ~write_n;

    // Per-bit debounce: count while the synchronized level disagrees, accept at the limit.
    always_comb begin
        deb_next_s = deb_r;
        cnt_next_s = '0;
        cnt_inc_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc_s[i] = cnt_r[i] + CNT_W'(1);
            if (sync2_r[i] != deb_r[i]) begin
                if (cnt_inc_s[i] == CNT_LIMIT) begin
                    deb_next_s[i] = sync2_r[i];
                    cnt_next_s[i] = '0;
                end else begin
                    cnt_next_s[i] = cnt_inc_s[i];
                end
            end else begin
                cnt_next_s[i] = '0;
            end
        end
    end

    // Register-file next state; a capture in the same cycle as its clear keeps the bit set.
    always_comb begin
        irqmask_next_s = irqmask_r;
        clear_mask_s   = '0;
        if (wr_s && (address == ADDR_MASK)) begin
            irqmask_next_s = writedata[WIDTH-1:0];
        end else begin
            irqmask_next_s = irqmask_r;
        end
        if (wr_s && (address == ADDR_EDGE)) begin
            clear_mask_s = writedata[WIDTH-1:0];
        end else begin
            clear_mask_s = '0;
        end
        edgecapture_next_s = (edgecapture_r & ~clear_mask_s) | rise_mask(deb_r, deb_next_s);
    end

    // Read mux is purely combinational on address so reads have no wait states.
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (address)
            ADDR_DATA: readdata_s = 32'(deb_r);
            ADDR_DIR:  readdata_s = 32'h0000_0000;
            ADDR_MASK: readdata_s = 32'(irqmask_r);
            ADDR_EDGE: readdata_s = 32'(edgecapture_r);
            default:   readdata_s = 32'h0000_0000;
        endcase
    end

    assign readdata = readdata_s;

    // All state, including the synchronizer, clears on reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r       <= '0;
            sync2_r       <= '0;
            deb_r         <= '0;
            cnt_r         <= '0;
            irqmask_r     <= '0;
            edgecapture_r <= '0;
            irq_r         <= 1'b0;
        end else begin
            sync1_r       <= in_port;
            sync2_r       <= sync1_r;
            deb_r         <= deb_next_s;
            cnt_r         <= cnt_next_s;
            irqmask_r     <= irqmask_next_s;
            edgecapture_r <= edgecapture_next_s;
            irq_r         <= |(edgecapture_next_s & irqmask_next_s);
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_unsaved_switch_in.sv
// Directed bench for unsaved_switch_in with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_unsaved_switch_in;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    unsaved_switch_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got %h expected %h", a, d, 32'h0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b expected %b", irq, 1'b0);
        end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] d;
        in_port = 8'h05;
        for (int k = 0; k < 5; k++) begin
            tick();
            rd(2'd0, d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL latency_early edge=N+%0d got %h expected %h", k, d, 32'h0);
            end
        end
        tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'h05) begin
            errors++;
            $display("FAIL latency_accept got %h expected %h", d, 32'h05);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h05) begin
            errors++;
            $display("FAIL latency_edgecap got %h expected %h", d, 32'h05);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL latency_irq_masked got %b expected %b", irq, 1'b0);
        end
        wr(2'd3, 32'hFF);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL w1c_all got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        in_port = 8'h0D;
        tick();
        tick();
        tick();
        in_port = 8'h05;
        for (int k = 0; k < 8; k++) begin
            tick();
            rd(2'd0, d);
            checks++;
            if (d !== 32'h05) begin
                errors++;
                $display("FAIL glitch_data cyc=%0d got %h expected %h", k, d, 32'h05);
            end
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL glitch_edgecap got %h expected %h", d, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL glitch_irq got %b expected %b", irq, 1'b0);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr(2'd2, 32'h01);
        in_port = 8'h04;
        for (int k = 0; k < 8; k++) tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL fall_data got %h expected %h", d, 32'h04);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL fall_not_captured got %h expected %h", d, 32'h0);
        end
        in_port = 8'h05;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert got %b expected %b", irq, 1'b1);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h01) begin
            errors++;
            $display("FAIL irq_edgecap got %h expected %h", d, 32'h01);
        end
        wr(2'd3, 32'h01);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL irq_clear_edgecap got %h expected %h", d, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b expected %b", irq, 1'b0);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        in_port = 8'h07;
        for (int k = 0; k < 5; k++) tick();
        wr(2'd3, 32'h02);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL set_wins got %h expected %h", d, 32'h02);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h07) begin
            errors++;
            $display("FAIL set_wins_data got %h expected %h", d, 32'h07);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_irq_masked got %b expected %b", irq, 1'b0);
        end
        wr(2'd2, 32'h02);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_enable_irq got %b expected %b", irq, 1'b1);
        end
        wr(2'd2, 32'h00);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_disable_irq got %b expected %b", irq, 1'b0);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h02) begin
            errors++;
            $display("FAIL mask_keeps_edgecap got %h expected %h", d, 32'h02);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        in_port = 8'hFF;
        tick();
        tick();
        reset      = 1'b1;
        address    = 2'd2;
        writedata  = 32'hFF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL midreset_read addr=%0d got %h expected %h", a, d, 32'h0);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq got %b expected %b", irq, 1'b0);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL redebounce_early got %h expected %h", d, 32'h0);
        end
        tick();
        tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'hFF) begin
            errors++;
            $display("FAIL redebounce_data got %h expected %h", d, 32'hFF);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'hFF) begin
            errors++;
            $display("FAIL redebounce_edgecap got %h expected %h", d, 32'hFF);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL write_in_reset_ignored got %h expected %h", d, 32'h0);
        end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] d;
        wr(2'd0, 32'hDEADBEEF);
        rd(2'd0, d);
        checks++;
        if (d !== 32'hFF) begin
            errors++;
            $display("FAIL write_addr0_ignored got %h expected %h", d, 32'hFF);
        end
        wr(2'd1, 32'hDEADBEEF);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL write_addr1_ignored got %h expected %h", d, 32'h0);
        end
        wr(2'd2, 32'hDEADBEEF);
        rd(2'd2, d);
        checks++;
        if (d !== 32'hEF) begin
            errors++;
            $display("FAIL irqmask_rw got %h expected %h", d, 32'hEF);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_mask got %b expected %b", irq, 1'b1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_irq();
        test_set_wins();
        test_reset_mid_debounce();
        test_ignored_writes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
